sysid_check_master: RTL and testbench

- Avalon-MM read master that interrogates a system-ID slave at startup or on request.
- Reads the ID word at word offset 0, then the timestamp word at word offset 1.
- Compares both words against expected values and reports pass/fail/timeout to a status register or LED logic.
- Sits beside the Nios II system as an independent hardware sanity check that the loaded FPGA image matches the software build.

---
 rtl/sysid_pkg.sv | 17 +
 rtl/sysid_timeout_counter.sv | 40 ++++
 rtl/sysid_check_master.sv | 141 ++++++++++++++
 tb/tb_sysid_check_master.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// Shared types and constants for the sysid check master.
package sysid_pkg;

    localparam int unsigned DATA_W = 32;

    // Byte offsets of the sysid slave registers.
    localparam int unsigned SYSID_ID_OFFSET = 0;
    localparam int unsigned SYSID_TS_OFFSET = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRdId,
        StRdTs,
        StFin
    } sysid_state_e;

endpackage

// File: rtl/sysid_timeout_counter.sv
// Stall counter for one Avalon read.
// expire_o pulses in the stall cycle that counts TimeoutCycles.
module sysid_timeout_counter #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;
    localparam logic [CntW-1:0] LastCount = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    // Next count: clear has priority over counting.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CntW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && (count_q == LastCount);

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that reads the sysid ID and timestamp words and
// compares them with the values baked into this build.
module sysid_check_master
    import sysid_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter logic [DATA_W-1:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [DATA_W-1:0] EXPECTED_TS    = 32'd1453490668,
    parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              id_ok,
    output logic              ts_ok,
    output logic              timeout,
    output logic [DATA_W-1:0] id_value,
    output logic [DATA_W-1:0] ts_value
);

    // Address arithmetic wraps naturally at ADDR_W bits.
    localparam logic [ADDR_W-1:0] IdAddr = BASE_ADDR + ADDR_W'(SYSID_ID_OFFSET);
    localparam logic [ADDR_W-1:0] TsAddr = BASE_ADDR + ADDR_W'(SYSID_TS_OFFSET);

    sysid_state_e      state_q;
    logic [ADDR_W-1:0] avm_address_q;
    logic              avm_read_q;
    logic              busy_q;
    logic              done_q;
    logic              id_ok_q;
    logic              ts_ok_q;
    logic              timeout_q;
    logic [DATA_W-1:0] id_value_q;
    logic [DATA_W-1:0] ts_value_q;

    logic cnt_enable;
    logic cnt_clear;
    logic cnt_expire;

    // The counter runs only while a read is stalled; any other cycle,
    // including an accept, returns it to zero for the next read.
    always_comb begin
        cnt_enable = ((state_q == StRdId) || (state_q == StRdTs)) && avm_waitrequest;
        cnt_clear  = !cnt_enable || cnt_expire;
    end

    sysid_timeout_counter #(
        .TimeoutCycles(TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .clear_i (cnt_clear),
        .enable_i(cnt_enable),
        .expire_o(cnt_expire)
    );

    // Control FSM with all outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            avm_address_q <= BASE_ADDR;
            avm_read_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_q     <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        id_ok_q       <= 1'b0;
                        ts_ok_q       <= 1'b0;
                        timeout_q     <= 1'b0;
                        busy_q        <= 1'b1;
                        avm_read_q    <= 1'b1;
                        avm_address_q <= IdAddr;
                        state_q       <= StRdId;
                    end
                end
                StRdId: begin
                    if (!avm_waitrequest) begin
                        id_value_q    <= avm_readdata;
                        id_ok_q       <= (avm_readdata == EXPECTED_ID);
                        avm_address_q <= TsAddr;
                        state_q       <= StRdTs;
                    end else if (cnt_expire) begin
                        // Skip the timestamp read entirely.
                        avm_read_q <= 1'b0;
                        timeout_q  <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= StFin;
                    end
                end
                StRdTs: begin
                    if (!avm_waitrequest) begin
                        ts_value_q <= avm_readdata;
                        ts_ok_q    <= (avm_readdata == EXPECTED_TS);
                        avm_read_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= StFin;
                    end else if (cnt_expire) begin
                        avm_read_q <= 1'b0;
                        timeout_q  <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= StFin;
                    end
                end
                StFin: begin
                    busy_q        <= 1'b0;
                    avm_address_q <= BASE_ADDR;
                    state_q       <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign avm_address = avm_address_q;
    assign avm_read    = avm_read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Randomized bench for sysid_check_master with an in-bench Avalon slave and
// a transaction-level model of the expected result of each check.
module tb_sysid_check_master;

    localparam int          T       = 8;
    localparam logic [31:0] BASE    = 32'hFFFF_FFFC;
    localparam logic [31:0] TS_ADDR = 32'h0000_0000;  // BASE + 4, wrapped
    localparam logic [31:0] EXP_ID  = 32'h0000_0000;
    localparam logic [31:0] EXP_TS  = 32'd1453490668;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int n_total;
    int n_bad;

    // Model of the sticky captured words.
    logic [31:0] m_id;
    logic [31:0] m_ts;

    sysid_check_master #(
        .ADDR_W        (32),
        .BASE_ADDR     (BASE),
        .EXPECTED_ID   (EXP_ID),
        .EXPECTED_TS   (EXP_TS),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .done           (done),
        .id_ok          (id_ok),
        .ts_ok          (ts_ok),
        .timeout        (timeout),
        .id_value       (id_value),
        .ts_value       (ts_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // One complete check: wid/wts are stall cycles the slave inserts on each
    // read (>= T means the read times out), did/dts the words returned, poke
    // re-pulses start while the master is busy.
    task automatic run_check(input int wid, input int wts, input logic [31:0] did,
                             input logic [31:0] dts, input bit poke);
        bit          to_id, to_ts;
        int          exp_done, exp_acc, exp_rdcyc;
        int          done_cnt, done_cyc, acc_cnt, rd_cyc, busy_cyc, late_rd, unstable;
        int          served, cur_wait;
        logic [31:0] acc_addr [2];
        logic [31:0] first_addr;
        bit          seen_rd, prev_rd, prev_wr;
        logic [31:0] prev_addr;

        to_id = (wid >= T);
        to_ts = !to_id && (wts >= T);
        if (to_id) begin
            exp_done = T + 1;       exp_acc = 0; exp_rdcyc = T;
        end else if (to_ts) begin
            exp_done = wid + 2 + T; exp_acc = 1; exp_rdcyc = wid + 1 + T;
        end else begin
            exp_done = wid + wts + 3; exp_acc = 2; exp_rdcyc = wid + wts + 2;
        end

        done_cnt = 0; done_cyc = -1; acc_cnt = 0; rd_cyc = 0; busy_cyc = 0;
        late_rd = 0; unstable = 0; served = 0;
        acc_addr[0] = '1; acc_addr[1] = '1; first_addr = '1;
        seen_rd = 0; prev_rd = 0; prev_wr = 0; prev_addr = '0;

        @(negedge clock);
        start = 1'b1;
        for (int c = 1; c <= exp_done + 3; c++) begin
            @(negedge clock);
            if (prev_rd && prev_wr && !((to_id || to_ts) && c == exp_done)) begin
                if (!avm_read || avm_address !== prev_addr) unstable++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (busy) busy_cyc++;
            if (avm_read) begin
                rd_cyc++;
                if (c > exp_done) late_rd++;
                if (!seen_rd) begin
                    first_addr = avm_address;
                    seen_rd    = 1;
                end
                cur_wait = (avm_address == TS_ADDR) ? wts : wid;
                if (served < cur_wait) begin
                    avm_waitrequest = 1'b1;
                    avm_readdata    = $urandom;
                    served++;
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata    = (avm_address == TS_ADDR) ? dts : did;
                    if (acc_cnt < 2) acc_addr[acc_cnt] = avm_address;
                    acc_cnt++;
                    served = 0;
                end
            end else begin
                avm_waitrequest = 1'($urandom_range(0, 1));
                avm_readdata    = $urandom;
                served          = 0;
            end
            prev_rd   = avm_read;
            prev_wr   = avm_waitrequest;
            prev_addr = avm_address;
            start     = poke && (c == 2 || c == exp_done);
        end
        start           = 1'b0;
        avm_waitrequest = 1'b0;

        if (!to_id) m_id = did;
        if (exp_acc == 2) m_ts = dts;

        check("done_count", done_cnt, 1);
        check("done_cycle", done_cyc, exp_done);
        check("busy_cycles", busy_cyc, exp_done);
        check("accepts", acc_cnt, exp_acc);
        check("read_cycles", rd_cyc, exp_rdcyc);
        check("late_reads", late_rd, 0);
        check("stall_stable", unstable, 0);
        check("first_addr", first_addr, BASE);
        if (exp_acc >= 1) check("id_addr", acc_addr[0], BASE);
        if (exp_acc == 2) check("ts_addr", acc_addr[1], TS_ADDR);
        check("id_ok", 32'(id_ok), 32'(!to_id && did == EXP_ID));
        check("ts_ok", 32'(ts_ok), 32'(exp_acc == 2 && dts == EXP_TS));
        check("timeout", 32'(timeout), 32'(to_id || to_ts));
        check("id_value", id_value, m_id);
        check("ts_value", ts_value, m_ts);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_addr", avm_address, BASE);
    endtask

    task automatic reset_mid_read();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start           = 1'b0;
        avm_waitrequest = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_pre_read", 32'(avm_read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_read", 32'(avm_read), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
        check("rst_async_id", id_value, 32'd0);
        check("rst_async_ts", ts_value, 32'd0);
        @(negedge clock);
        reset_n         = 1'b1;
        avm_waitrequest = 1'b0;
        m_id            = '0;
        m_ts            = '0;
    endtask

    initial begin
        int          wid, wts;
        logic [31:0] did, dts;

        n_total = 0;
        n_bad   = 0;
        m_id    = '0;
        m_ts    = '0;
        reset_n         = 1'b0;
        start           = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata    = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        check("reset_read", 32'(avm_read), 32'd0);
        check("reset_addr", avm_address, BASE);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
        check("reset_id", id_value, 32'd0);
        check("reset_ts", ts_value, 32'd0);

        run_check(0, 0, EXP_ID, EXP_TS, 0);
        run_check(0, 0, 32'h1, 32'd5, 0);
        run_check(3, 3, EXP_ID, EXP_TS, 0);
        run_check(1000, 0, EXP_ID, EXP_TS, 0);
        run_check(0, 0, EXP_ID, EXP_TS, 0);
        run_check(T - 1, T - 1, EXP_ID, EXP_TS, 0);
        run_check(2, T, EXP_ID, EXP_TS, 0);
        run_check(0, 0, EXP_ID, EXP_TS, 1);
        reset_mid_read();
        run_check(0, 0, EXP_ID, EXP_TS, 0);

        for (int i = 0; i < 40; i++) begin
            wid = ($urandom_range(0, 5) == 0) ? T + int'($urandom_range(0, 2))
                                              : int'($urandom_range(0, T - 1));
            wts = ($urandom_range(0, 5) == 0) ? T + int'($urandom_range(0, 2))
                                              : int'($urandom_range(0, T - 1));
            did = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
            dts = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
            run_check(wid, wts, did, dts, bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
